// File: rtl/sum_pkg.sv
// Shared types and constants for the sum responder.
// Holds the FSM state encoding and the default datapath width.
package sum_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/accum_unit.sv
// Accumulator with sticky carry-out flag and saturating operand counter.
// Load restarts a sum; add folds one operand into it.
module accum_unit
  import sum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             load,
  input  logic             add,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, acc} + {1'b0, din};

  always_ff @(posedge ck) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      acc <= din;
      cnt <= CNT_ONE;
      ovf <= 1'b0;
    end else if (add) begin
      acc <= sum[WIDTH-1:0];
      if (cnt != CNT_MAX)
        cnt <= cnt + CNT_ONE;
      if (sum[WIDTH])
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/sum_responder.sv
// Sums an operand stream started by go_l and terminated by a zero operand.
// done is combinational so the initiator sees it in the terminating cycle.
module sum_responder
  import sum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             go_l,
  input  logic [WIDTH-1:0] inA,
  output logic             done,
  output logic [WIDTH-1:0] outResult,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  state_t state_q;
  state_t state_d;
  logic   load;
  logic   add;
  logic   zero;

  assign zero = (inA == '0);

  always_ff @(posedge ck) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    add     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (!go_l) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (zero) begin
          done    = 1'b1;
          state_d = DONE;
        end else begin
          add = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  accum_unit #(.WIDTH(WIDTH)) u_acc (
    .ck    (ck),
    .reset (reset),
    .load  (load),
    .add   (add),
    .din   (inA),
    .acc   (outResult),
    .cnt   (count),
    .ovf   (overflow)
  );

endmodule

// File: tb/tb_sum_responder.sv
// Directed bench for sum_responder.
// Expected values are hand-computed or from a small mod-256 sum model.
module tb_sum_responder;

  logic       ck;
  logic       reset;
  logic       go_l;
  logic [7:0] inA;
  logic       done;
  logic [7:0] outResult;
  logic [7:0] count;
  logic       overflow;

  int checks;
  int errors;
  int done_seen;

  sum_responder #(.WIDTH(8)) dut (
    .ck        (ck),
    .reset     (reset),
    .go_l      (go_l),
    .inA       (inA),
    .done      (done),
    .outResult (outResult),
    .count     (count),
    .overflow  (overflow)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check done before the edge.
  task automatic cyc(
    input logic       g,
    input logic [7:0] a,
    input logic       exp_done
  );
    go_l = g;
    inA  = a;
    #1;
    chk("done", {31'd0, done}, {31'd0, exp_done});
    if (done === 1'b1)
      done_seen++;
    @(posedge ck);
    #1;
  endtask

  task automatic chk_regs(
    input string      tag,
    input logic [7:0] r,
    input logic [7:0] c,
    input logic       o
  );
    chk({tag, "_res"}, {24'd0, outResult}, {24'd0, r});
    chk({tag, "_cnt"}, {24'd0, count}, {24'd0, c});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, o});
  endtask

  initial begin
    logic [7:0] ref_sum;
    logic [7:0] v;
    checks    = 0;
    errors    = 0;
    done_seen = 0;
    reset     = 1'b1;
    go_l      = 1'b1;
    inA       = 8'd0;
    @(posedge ck);
    @(posedge ck);
    #1;
    reset = 1'b0;
    #1;
    chk_regs("rst", 8'd0, 8'd0, 1'b0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge ck);
    #1;

    // basic sum
    cyc(1'b0, 8'd5, 1'b0);
    cyc(1'b1, 8'd3, 1'b0);
    cyc(1'b1, 8'd7, 1'b0);
    cyc(1'b1, 8'd0, 1'b1);
    chk_regs("basic", 8'd15, 8'd3, 1'b0);
    cyc(1'b1, 8'd0, 1'b0);
    chk_regs("hold", 8'd15, 8'd3, 1'b0);

    // overflow
    cyc(1'b0, 8'd200, 1'b0);
    cyc(1'b1, 8'd100, 1'b0);
    cyc(1'b1, 8'd0, 1'b1);
    chk_regs("ovf", 8'd44, 8'd2, 1'b1);

    // go-cycle zero is not a terminator
    cyc(1'b0, 8'd0, 1'b0);
    chk_regs("gozero", 8'd0, 8'd1, 1'b0);
    cyc(1'b1, 8'd4, 1'b0);
    cyc(1'b1, 8'd0, 1'b1);
    chk_regs("gozero_end", 8'd4, 8'd2, 1'b0);

    // mid-run reset
    cyc(1'b0, 8'd9, 1'b0);
    cyc(1'b1, 8'd9, 1'b0);
    reset = 1'b1;
    go_l  = 1'b1;
    inA   = 8'd9;
    @(posedge ck);
    #1;
    reset = 1'b0;
    inA   = 8'd0;
    #1;
    chk_regs("midrst", 8'd0, 8'd0, 1'b0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(posedge ck);
    #1;
    cyc(1'b1, 8'd0, 1'b0);
    chk_regs("idle", 8'd0, 8'd0, 1'b0);
    cyc(1'b0, 8'd1, 1'b0);
    cyc(1'b1, 8'd0, 1'b1);
    chk_regs("after_rst", 8'd1, 8'd1, 1'b0);

    // go_l ignored in RUN, honoured in DONE
    cyc(1'b0, 8'd250, 1'b0);
    cyc(1'b0, 8'd10, 1'b0);
    cyc(1'b1, 8'd0, 1'b1);
    chk_regs("pre_ovf", 8'd4, 8'd2, 1'b1);
    cyc(1'b0, 8'd2, 1'b0);
    cyc(1'b0, 8'd3, 1'b0);
    cyc(1'b0, 8'd0, 1'b1);
    chk_regs("goign", 8'd5, 8'd2, 1'b0);
    cyc(1'b0, 8'd6, 1'b0);
    chk_regs("reload", 8'd6, 8'd1, 1'b0);
    cyc(1'b1, 8'd0, 1'b1);

    // long stream with count saturation
    done_seen = 0;
    ref_sum   = 8'd1;
    cyc(1'b0, 8'd1, 1'b0);
    for (int i = 0; i < 299; i++) begin
      v       = 8'((i % 255) + 1);
      ref_sum = ref_sum + v;
      cyc(1'b1, v, 1'b0);
    end
    cyc(1'b1, 8'd0, 1'b1);
    chk_regs("long", ref_sum, 8'd255, 1'b1);
    chk("long_once", done_seen, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_responder.md
SUM_RESPONDER -- requirements
Module: sum_responder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port ck  input  1  single clock; all state updates on posedge ck.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port go_l  input  1  active-low one-cycle start strobe from the initiator.
REQ-005 The block SHALL have port inA  input  WIDTH  operand stream, one value per cycle.
REQ-006 The block SHALL have port done  output  1  termination indication, combinational.
REQ-007 The block SHALL have port outResult  output  WIDTH  registered accumulated sum.
REQ-008 The block SHALL have port count  output  WIDTH  registered number of operands accumulated.
REQ-009 The block SHALL have port overflow  output  1  registered sticky carry-out flag.

Function
REQ-010 The block SHALL implement states IDLE, RUN and DONE.
REQ-011 In IDLE with go_l low, the block SHALL load acc<=inA, count<=1 and overflow<=0, and go to RUN; this go-cycle value SHALL NOT be tested for zero.
REQ-012 In IDLE with go_l high, the block SHALL hold all registers.
REQ-013 In RUN with inA!=0, the block SHALL set acc<=acc+inA (mod 2^WIDTH) and count<=count+1 (saturating at 2^WIDTH-1), and stay in RUN.
REQ-014 In RUN, a carry-out from acc+inA SHALL set overflow<=1; overflow SHALL stay set until the next load.
REQ-015 In RUN with inA==0, done SHALL be 1 in that same cycle, acc/count/overflow SHALL hold, and the next state SHALL be DONE.
REQ-016 done SHALL be 0 in every state/input combination other than REQ-015; zero added latency is mandatory because the initiator stops summing in the cycle it sees done.
REQ-017 In RUN, go_l SHALL be ignored.
REQ-018 In DONE, outResult, count and overflow SHALL hold stable.
REQ-019 In DONE with go_l low, the block SHALL perform the REQ-011 load and go to RUN.
REQ-020 outResult SHALL equal acc at all times.
REQ-021 The 8-bit sum SHALL equal the initiator's running sum: go-cycle value plus each RUN-cycle value before the terminating zero.

Reset
REQ-022 With reset high at a posedge, the block SHALL set state=IDLE, acc=0, count=0 and overflow=0, overriding any other event in that cycle.
REQ-023 Reset SHALL abort RUN or DONE with no partial result retained; done SHALL be 0 on the cycle after reset.

Structure
REQ-024 The state enum and the default WIDTH constant SHALL live in a shared package, sum_pkg.
REQ-025 The adder with carry-out and the saturating counter SHALL be one sub-module, accum_unit; the FSM SHALL stay in sum_responder.

Verification
REQ-026 Basic sum: go with inA=5, then 3, 7, 0 -> done=1 only in the cycle inA=0; afterwards outResult=15, count=3, overflow=0.
REQ-027 Overflow: go with 200, then 100, 0 -> outResult=44, overflow=1, count=2.
REQ-028 Go-cycle zero: go with 0, then 4, 0 -> no done on the go cycle; done on the second zero; outResult=4, count=2.
REQ-029 Mid-run reset: go with 9, then 9, then reset asserted one cycle -> state IDLE, outResult=0, count=0, done=0; later go with 1, then 0 -> outResult=1.
REQ-030 Go handling: go_l held low throughout RUN is ignored (go 2, 3, 0 -> outResult=5); go_l low in DONE with inA=6 -> RUN with outResult=6, overflow=0.
REQ-031 Long stream: go with 1, then 299 nonzero values, then 0 -> count saturates at 255; outResult matches the mod-256 reference sum; done occurs exactly once.
